// File: rtl/shared_ram_pkg.sv
// Shared RAM arbiter types: FSM states and access owner encoding.
package shared_ram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAITQ  = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_M68K = 1'b0,
        OWN_Z80  = 1'b1
    } owner_t;

    localparam int ADDR_W_DEF  = 11;
    localparam int RAM_LAT_DEF = 1;

    // Terminal value of the 2-bit WAITQ counter for a given BRAM latency (1..3).
    function automatic logic [1:0] lat_last(input int lat);
        return 2'(lat - 1);
    endfunction

endpackage

// File: rtl/shared_ram_arbiter.sv
// Shares one byte-wide BRAM port between the M68K (low lane, DTACK) and the Z80 (WAIT).
// Accesses are serialised through IDLE -> ACCESS -> WAITQ -> DONE; ties alternate.
module shared_ram_arbiter
    import shared_ram_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int RAM_LAT = RAM_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m68k_req,
    input  logic              m68k_rw,
    input  logic              m68k_lds_n,
    input  logic [ADDR_W-1:0] m68k_addr,
    input  logic [7:0]        m68k_din,
    output logic [15:0]       m68k_dout,
    output logic              m68k_dtack_n,
    input  logic              z80_req,
    input  logic              z80_wr,
    input  logic [ADDR_W-1:0] z80_addr,
    input  logic [7:0]        z80_din,
    output logic [7:0]        z80_dout,
    output logic              z80_wait_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_d,
    input  logic [7:0]        ram_q
);

    localparam logic [1:0] CNT_LAST = lat_last(RAM_LAT);

    arb_state_t        state_r;
    logic [1:0]        cnt_r;
    owner_t            owner_r;
    owner_t            last_grant_r;
    logic [ADDR_W-1:0] acc_addr_r;
    logic [7:0]        acc_data_r;
    logic              acc_we_r;
    logic              acc_rd_r;
    logic              m68k_served_r;
    logic              m68k_done_r;
    logic              m68k_dtack_n_r;
    logic [7:0]        m68k_byte_r;
    logic              z80_served_r;
    logic              z80_done_r;
    logic [7:0]        z80_dout_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic              ram_we_r;
    logic [7:0]        ram_d_r;

    logic              m68k_pend_s;
    logic              z80_pend_s;
    logic              grant_valid_s;
    owner_t            grant_s;
    logic [ADDR_W-1:0] cap_addr_s;
    logic [7:0]        cap_data_s;
    logic              cap_we_s;
    logic              cap_rd_s;

    assign m68k_pend_s = m68k_req & ~m68k_served_r;
    assign z80_pend_s  = z80_req & ~z80_served_r;

    // Pick the next owner: the single pending requester, or on a tie the one not granted last.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_s       = OWN_M68K;
        if (m68k_pend_s && z80_pend_s) begin
            grant_valid_s = 1'b1;
            grant_s       = (last_grant_r == OWN_M68K) ? OWN_Z80 : OWN_M68K;
        end else if (m68k_pend_s) begin
            grant_valid_s = 1'b1;
            grant_s       = OWN_M68K;
        end else if (z80_pend_s) begin
            grant_valid_s = 1'b1;
            grant_s       = OWN_Z80;
        end else begin
            grant_valid_s = 1'b0;
            grant_s       = OWN_M68K;
        end
    end

    // Select the granted requester's address, data and direction for capture.
    // An M68K write with only the upper strobe completes without touching the RAM.
    always_comb begin
        cap_addr_s = m68k_addr;
        cap_data_s = m68k_din;
        cap_we_s   = 1'b0;
        cap_rd_s   = 1'b0;
        if (grant_s == OWN_Z80) begin
            cap_addr_s = z80_addr;
            cap_data_s = z80_din;
            cap_we_s   = z80_wr;
            cap_rd_s   = ~z80_wr;
        end else begin
            cap_addr_s = m68k_addr;
            cap_data_s = m68k_din;
            cap_we_s   = ~m68k_rw & ~m68k_lds_n;
            cap_rd_s   = m68k_rw;
        end
    end

    // Arbiter FSM with per-requester served/done bookkeeping and registered RAM/ack outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            cnt_r          <= 2'd0;
            owner_r        <= OWN_M68K;
            last_grant_r   <= OWN_Z80;
            acc_addr_r     <= '0;
            acc_data_r     <= 8'h00;
            acc_we_r       <= 1'b0;
            acc_rd_r       <= 1'b0;
            m68k_served_r  <= 1'b0;
            m68k_done_r    <= 1'b0;
            m68k_dtack_n_r <= 1'b1;
            m68k_byte_r    <= 8'h00;
            z80_served_r   <= 1'b0;
            z80_done_r     <= 1'b0;
            z80_dout_r     <= 8'h00;
            ram_addr_r     <= '0;
            ram_we_r       <= 1'b0;
            ram_d_r        <= 8'h00;
        end else begin
            ram_we_r <= 1'b0;

            // A dropped request ends the bus cycle: forget service and release the ack.
            if (!m68k_req) begin
                m68k_served_r  <= 1'b0;
                m68k_done_r    <= 1'b0;
                m68k_dtack_n_r <= 1'b1;
            end
            if (!z80_req) begin
                z80_served_r <= 1'b0;
                z80_done_r   <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        owner_r    <= grant_s;
                        acc_addr_r <= cap_addr_s;
                        acc_data_r <= cap_data_s;
                        acc_we_r   <= cap_we_s;
                        acc_rd_r   <= cap_rd_s;
                        state_r    <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    ram_addr_r <= acc_addr_r;
                    ram_d_r    <= acc_data_r;
                    ram_we_r   <= acc_we_r;
                    cnt_r      <= 2'd0;
                    state_r    <= WAITQ;
                end
                WAITQ: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 2'd1;
                    end
                end
                DONE: begin
                    last_grant_r <= owner_r;
                    state_r      <= IDLE;
                    if (owner_r == OWN_M68K) begin
                        if (acc_rd_r) begin
                            m68k_byte_r <= ram_q;
                        end
                        // A withdrawn request still completes but is not acknowledged.
                        if (m68k_req) begin
                            m68k_served_r  <= 1'b1;
                            m68k_done_r    <= 1'b1;
                            m68k_dtack_n_r <= 1'b0;
                        end
                    end else begin
                        if (acc_rd_r) begin
                            z80_dout_r <= ram_q;
                        end
                        if (z80_req) begin
                            z80_served_r <= 1'b1;
                            z80_done_r   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign m68k_dout    = {8'hff, m68k_byte_r};
    assign m68k_dtack_n = m68k_dtack_n_r;
    assign z80_dout     = z80_dout_r;
    // WAIT must react in the same cycle as the Z80 strobe, so it stays combinational.
    assign z80_wait_n   = reset | ~(z80_req & ~z80_done_r);
    assign ram_addr     = ram_addr_r;
    assign ram_we       = ram_we_r;
    assign ram_d        = ram_d_r;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Scoreboard bench for shared_ram_arbiter: two instances (RAM_LAT 1 and 3), each with a BRAM model.
module tb_shared_ram_arbiter;

    typedef struct {
        int          inst;
        bit          is_z80;
        bit          chk_data;
        logic [15:0] data;
        int          ack_cyc;
    } ack_t;

    typedef struct {
        int          inst;
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk;
    logic        reset        [2];
    logic        m68k_req     [2];
    logic        m68k_rw      [2];
    logic        m68k_lds_n   [2];
    logic [10:0] m68k_addr    [2];
    logic [7:0]  m68k_din     [2];
    logic [15:0] m68k_dout    [2];
    logic        m68k_dtack_n [2];
    logic        z80_req      [2];
    logic        z80_wr       [2];
    logic [10:0] z80_addr     [2];
    logic [7:0]  z80_din      [2];
    logic [7:0]  z80_dout     [2];
    logic        z80_wait_n   [2];
    logic [10:0] ram_addr     [2];
    logic        ram_we       [2];
    logic [7:0]  ram_d        [2];
    logic [7:0]  ram_q        [2];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ack_t ack_q[$];
    wr_t  wr_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [7:0] mem  [0:2047];
        logic [7:0] pipe [0:2];
        logic       prev_dtack = 1'b1;
        logic       prev_wait  = 1'b1;

        shared_ram_arbiter #(.ADDR_W(11), .RAM_LAT(LAT)) dut (
            .clk         (clk),
            .reset       (reset[g]),
            .m68k_req    (m68k_req[g]),
            .m68k_rw     (m68k_rw[g]),
            .m68k_lds_n  (m68k_lds_n[g]),
            .m68k_addr   (m68k_addr[g]),
            .m68k_din    (m68k_din[g]),
            .m68k_dout   (m68k_dout[g]),
            .m68k_dtack_n(m68k_dtack_n[g]),
            .z80_req     (z80_req[g]),
            .z80_wr      (z80_wr[g]),
            .z80_addr    (z80_addr[g]),
            .z80_din     (z80_din[g]),
            .z80_dout    (z80_dout[g]),
            .z80_wait_n  (z80_wait_n[g]),
            .ram_addr    (ram_addr[g]),
            .ram_we      (ram_we[g]),
            .ram_d       (ram_d[g]),
            .ram_q       (ram_q[g])
        );

        // BRAM model: synchronous write, read data delayed LAT cycles after the address.
        always @(posedge clk) begin
            if (ram_we[g]) mem[ram_addr[g]] <= ram_d[g];
            pipe[0] <= mem[ram_addr[g]];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign ram_q[g] = pipe[LAT-1];

        // Monitor: every ack edge and every RAM write is matched against the scoreboard queues.
        always @(negedge clk) begin
            if (!m68k_dtack_n[g] && prev_dtack) begin
                if (ack_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_m68k_ack inst=%0d cycle=%0d expected none", g, cyc);
                end else begin
                    chk("m68k_ack_inst", 32'(g), 32'(ack_q[0].inst));
                    chk("m68k_ack_owner", 32'd0, 32'(ack_q[0].is_z80));
                    chk("m68k_ack_cycle", 32'(cyc), 32'(ack_q[0].ack_cyc));
                    if (ack_q[0].chk_data) chk("m68k_dout", {16'h0, m68k_dout[g]}, {16'h0, ack_q[0].data});
                    void'(ack_q.pop_front());
                end
            end
            if (z80_req[g] && z80_wait_n[g] && !prev_wait) begin
                if (ack_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_z80_ack inst=%0d cycle=%0d expected none", g, cyc);
                end else begin
                    chk("z80_ack_inst", 32'(g), 32'(ack_q[0].inst));
                    chk("z80_ack_owner", 32'd1, 32'(ack_q[0].is_z80));
                    chk("z80_ack_cycle", 32'(cyc), 32'(ack_q[0].ack_cyc));
                    if (ack_q[0].chk_data) chk("z80_dout", {24'h0, z80_dout[g]}, {16'h0, ack_q[0].data});
                    void'(ack_q.pop_front());
                end
            end
            if (ram_we[g]) begin
                if (wr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ram_write inst=%0d addr=%h data=%h expected none", g, ram_addr[g], ram_d[g]);
                end else begin
                    chk("ram_write_inst", 32'(g), 32'(wr_q[0].inst));
                    chk("ram_addr", {21'h0, ram_addr[g]}, {21'h0, wr_q[0].addr});
                    chk("ram_d", {24'h0, ram_d[g]}, {24'h0, wr_q[0].data});
                    void'(wr_q.pop_front());
                end
            end
            prev_dtack <= m68k_dtack_n[g];
            prev_wait  <= z80_wait_n[g];
        end
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ack(input int d, input bit is_z80, input bit chk_data, input logic [15:0] data, input int ack_cyc);
        ack_t a;
        a.inst = d; a.is_z80 = is_z80; a.chk_data = chk_data; a.data = data; a.ack_cyc = ack_cyc;
        ack_q.push_back(a);
    endtask

    task automatic push_wr(input int d, input logic [10:0] addr, input logic [7:0] data);
        wr_t w;
        w.inst = d; w.addr = addr; w.data = data;
        wr_q.push_back(w);
    endtask

    // Bounded wait for all expected acks and writes to be consumed by the monitor.
    task automatic wait_drain(input string name);
        int n = 0;
        while ((ack_q.size() != 0 || wr_q.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, 32'(ack_q.size() + wr_q.size()), 32'd0);
        ack_q.delete();
        wr_q.delete();
    endtask

    task automatic reset_chk(input int d);
        reset[d] = 1'b1;
        z80_req[d] = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_wait_n_forced", 32'(z80_wait_n[d]), 32'd1);
        chk("rst_dtack_n", 32'(m68k_dtack_n[d]), 32'd1);
        chk("rst_m68k_dout", {16'h0, m68k_dout[d]}, 32'h0000ff00);
        chk("rst_z80_dout", {24'h0, z80_dout[d]}, 32'd0);
        chk("rst_ram_we", 32'(ram_we[d]), 32'd0);
        chk("rst_ram_addr", {21'h0, ram_addr[d]}, 32'd0);
        chk("rst_ram_d", {24'h0, ram_d[d]}, 32'd0);
        tick();
        z80_req[d] = 1'b0;
        tick();
        reset[d] = 1'b0;
        tick();
    endtask

    task automatic m68k_access(input int d, input logic rw, input logic lds_n, input logic [10:0] addr,
                               input logic [7:0] din, input logic [7:0] exp_byte);
        int n;
        m68k_rw[d] = rw; m68k_lds_n[d] = lds_n; m68k_addr[d] = addr; m68k_din[d] = din;
        m68k_req[d] = 1'b1;
        n = cyc;
        push_ack(d, 1'b0, rw, {8'hff, exp_byte}, n + lat_of(d) + 3);
        if (!rw && !lds_n) push_wr(d, addr, din);
        wait_drain("m68k_access");
        m68k_req[d] = 1'b0;
        tick();
        tick();
    endtask

    task automatic z80_access(input int d, input logic wr, input logic [10:0] addr,
                              input logic [7:0] din, input logic [7:0] exp_byte);
        int n;
        z80_wr[d] = wr; z80_addr[d] = addr; z80_din[d] = din;
        z80_req[d] = 1'b1;
        n = cyc;
        #1;
        chk("z80_wait_low_on_req", 32'(z80_wait_n[d]), 32'd0);
        push_ack(d, 1'b1, ~wr, {8'h00, exp_byte}, n + lat_of(d) + 3);
        if (wr) push_wr(d, addr, din);
        wait_drain("z80_access");
        z80_req[d] = 1'b0;
        tick();
        tick();
    endtask

    // Simultaneous reads: the M68K must win after reset or after a Z80 grant.
    task automatic tie(input int d, input logic [10:0] m_addr, input logic [7:0] m_exp,
                       input logic [10:0] z_addr, input logic [7:0] z_exp);
        int n;
        m68k_rw[d] = 1'b1; m68k_lds_n[d] = 1'b0; m68k_addr[d] = m_addr;
        z80_wr[d] = 1'b0; z80_addr[d] = z_addr;
        m68k_req[d] = 1'b1;
        z80_req[d] = 1'b1;
        n = cyc;
        push_ack(d, 1'b0, 1'b1, {8'hff, m_exp}, n + lat_of(d) + 3);
        push_ack(d, 1'b1, 1'b1, {8'h00, z_exp}, n + 2 * lat_of(d) + 6);
        wait_drain("tie");
        m68k_req[d] = 1'b0;
        z80_req[d] = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // M68K write held for 20 cycles: one RAM write, DTACK held, released one cycle after req drops.
    task automatic held_write(input int d);
        int n;
        int highs = 0;
        m68k_rw[d] = 1'b0; m68k_lds_n[d] = 1'b0; m68k_addr[d] = 11'h010; m68k_din[d] = 8'hc3;
        m68k_req[d] = 1'b1;
        n = cyc;
        push_ack(d, 1'b0, 1'b0, 16'h0000, n + lat_of(d) + 3);
        push_wr(d, 11'h010, 8'hc3);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cyc >= n + lat_of(d) + 3 && m68k_dtack_n[d]) highs++;
        end
        chk("held_dtack_high_cycles", 32'(highs), 32'd0);
        wait_drain("held_write");
        m68k_req[d] = 1'b0;
        @(negedge clk);
        chk("held_dtack_before_release", 32'(m68k_dtack_n[d]), 32'd0);
        @(posedge clk);
        #1;
        chk("held_dtack_after_release", 32'(m68k_dtack_n[d]), 32'd1);
        tick();
        tick();
    endtask

    // Z80 write withdrawn during WAITQ: RAM still written, no ack, later read sees the data.
    task automatic withdrawn_write(input int d);
        z80_wr[d] = 1'b1; z80_addr[d] = 11'h020; z80_din[d] = 8'h33;
        z80_req[d] = 1'b1;
        push_wr(d, 11'h020, 8'h33);
        tick();
        tick();
        z80_req[d] = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        wait_drain("withdrawn_write");
        z80_access(d, 1'b0, 11'h020, 8'h00, 8'h33);
    endtask

    // Reset during the ACCESS cycle of an M68K write aborts it with no write and no ack.
    task automatic reset_in_access(input int d);
        m68k_rw[d] = 1'b0; m68k_lds_n[d] = 1'b0; m68k_addr[d] = 11'h030; m68k_din[d] = 8'h77;
        m68k_req[d] = 1'b1;
        tick();
        reset[d] = 1'b1;
        tick();
        @(negedge clk);
        chk("abort_ram_we", 32'(ram_we[d]), 32'd0);
        chk("abort_dtack_n", 32'(m68k_dtack_n[d]), 32'd1);
        chk("abort_ram_addr", {21'h0, ram_addr[d]}, 32'd0);
        @(posedge clk);
        #1;
        m68k_req[d] = 1'b0;
        tick();
        reset[d] = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1;
            m68k_req[i] = 1'b0; m68k_rw[i] = 1'b1; m68k_lds_n[i] = 1'b1;
            m68k_addr[i] = 11'h000; m68k_din[i] = 8'h00;
            z80_req[i] = 1'b0; z80_wr[i] = 1'b0; z80_addr[i] = 11'h000; z80_din[i] = 8'h00;
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            reset_chk(d);
            m68k_access(d, 1'b0, 1'b0, 11'h008, 8'h5a, 8'h00);
            z80_access(d, 1'b0, 11'h008, 8'h00, 8'h5a);
            m68k_access(d, 1'b1, 1'b0, 11'h008, 8'h00, 8'h5a);
            m68k_access(d, 1'b0, 1'b1, 11'h040, 8'hee, 8'h00);
            z80_access(d, 1'b1, 11'h050, 8'ha7, 8'h00);
            m68k_access(d, 1'b1, 1'b0, 11'h050, 8'h00, 8'ha7);
            held_write(d);
            withdrawn_write(d);
            reset_in_access(d);
            tie(d, 11'h010, 8'hc3, 11'h020, 8'h33);
            tie(d, 11'h008, 8'h5a, 11'h050, 8'ha7);
            reset[d] = 1'b1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
